// File: rtl/regfile_2r1w_sb.sv
// Integer register file for the npc core: two combinational read ports, one write port,
// optional write-to-read forwarding and a per-register pending-write scoreboard.
module regfile_2r1w_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic                  rs1_busy,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rs2_busy,
    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_addr,
    output logic                  any_busy
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam bit BYP  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [NREG-1:1];
    logic [DATA_WIDTH-1:0] regs_d [NREG-1:1];
    logic [NREG-1:1]       busy_q;
    logic [NREG-1:1]       busy_d;

    // Register 0 is presented as a constant zero entry so read ports can index directly.
    logic [DATA_WIDTH-1:0] rd_view_s [NREG];
    logic [NREG-1:0]       busy_view_s;
    logic                  fwd1_s;
    logic                  fwd2_s;

    // Next-state for storage and scoreboard; a set of the same index beats the writeback clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (wen && (rd_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = rd_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
            if (sb_set && (sb_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wen && (rd_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // State registers with synchronous reset taking priority over write and set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
            busy_q <= {(NREG-1){1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Flattened read views with the hardwired zero register at index 0.
    always_comb begin
        rd_view_s[0] = {DATA_WIDTH{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            rd_view_s[i] = regs_q[i];
        end
        busy_view_s = {busy_q, 1'b0};
    end

    assign fwd1_s = BYP && wen && (rd_addr == rs1_addr);
    assign fwd2_s = BYP && wen && (rd_addr == rs2_addr);

    // Read port 1: forwarded write data hides the pending bit it is about to clear.
    always_comb begin
        if (rs1_addr == {ADDR_WIDTH{1'b0}}) begin
            rs1_data = {DATA_WIDTH{1'b0}};
            rs1_busy = 1'b0;
        end else if (fwd1_s) begin
            rs1_data = rd_data;
            rs1_busy = 1'b0;
        end else begin
            rs1_data = rd_view_s[rs1_addr];
            rs1_busy = busy_view_s[rs1_addr];
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        if (rs2_addr == {ADDR_WIDTH{1'b0}}) begin
            rs2_data = {DATA_WIDTH{1'b0}};
            rs2_busy = 1'b0;
        end else if (fwd2_s) begin
            rs2_data = rd_data;
            rs2_busy = 1'b0;
        end else begin
            rs2_data = rd_view_s[rs2_addr];
            rs2_busy = busy_view_s[rs2_addr];
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench: a forwarding and a non-forwarding register file driven in parallel
// against a behavioural model; expectations are queued at drive time, popped at sample time.
module tb_regfile_2r1w_sb;

    logic        clk = 1'b0;
    logic        rst, wen, sb_set;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr, sb_addr;
    logic [31:0] rd_data;
    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic        rs1_busy, rs2_busy, any_busy, nb_rs1_busy, nb_rs2_busy, nb_any_busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    regfile_2r1w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_busy)
    );

    regfile_2r1w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs1_data(nb_rs1_data), .rs1_busy(nb_rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(nb_rs2_data), .rs2_busy(nb_rs2_busy),
        .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(nb_any_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        else if (byp && wen && rd_addr == a) return rd_data;
        else return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        else if (byp && wen && rd_addr == a) return 32'd0;
        else return {31'd0, m_busy[a]};
    endfunction

    task automatic push_exp();
        exp_q.push_back('{"rs1_data",    exp_data(rs1_addr, 1'b1)});
        exp_q.push_back('{"rs1_busy",    exp_busy(rs1_addr, 1'b1)});
        exp_q.push_back('{"rs2_data",    exp_data(rs2_addr, 1'b1)});
        exp_q.push_back('{"rs2_busy",    exp_busy(rs2_addr, 1'b1)});
        exp_q.push_back('{"any_busy",    {31'd0, |m_busy}});
        exp_q.push_back('{"nb_rs1_data", exp_data(rs1_addr, 1'b0)});
        exp_q.push_back('{"nb_rs1_busy", exp_busy(rs1_addr, 1'b0)});
        exp_q.push_back('{"nb_rs2_data", exp_data(rs2_addr, 1'b0)});
        exp_q.push_back('{"nb_rs2_busy", exp_busy(rs2_addr, 1'b0)});
        exp_q.push_back('{"nb_any_busy", {31'd0, |m_busy}});
    endtask

    function automatic logic [31:0] actual(input int k);
        case (k)
            0: return rs1_data;
            1: return {31'd0, rs1_busy};
            2: return rs2_data;
            3: return {31'd0, rs2_busy};
            4: return {31'd0, any_busy};
            5: return nb_rs1_data;
            6: return {31'd0, nb_rs1_busy};
            7: return nb_rs2_data;
            8: return {31'd0, nb_rs2_busy};
            default: return {31'd0, nb_any_busy};
        endcase
    endfunction

    // Drive-time expectations, then pop and compare on the falling edge.
    task automatic sample();
        exp_t e;
        push_exp();
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            e = exp_q.pop_front();
            check_eq(e.tag, actual(k), e.exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
            m_busy = 32'd0;
        end else begin
            if (wen && rd_addr != 5'd0) m_reg[rd_addr] = rd_data;
            for (int i = 1; i < 32; i++) begin
                if (sb_set && sb_addr == 5'(i)) m_busy[i] = 1'b1;
                else if (wen && rd_addr == 5'(i)) m_busy[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; sb_set = 1'b0;
        rd_addr = 5'd0; rd_data = 32'd0; sb_addr = 5'd0;
    endtask

    initial begin
        idle();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        rst = 1'b1;
        advance();

        // Reset then read
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd31;
        sample();
        check_eq("rst_rs1", rs1_data, 32'd0);
        check_eq("rst_any", {31'd0, any_busy}, 32'd0);
        advance();

        // Write, read back, x0 writes ignored
        wen = 1'b1; rd_addr = 5'd3; rd_data = 32'hDEADBEEF;
        sample(); advance();
        idle(); rs1_addr = 5'd3;
        sample(); check_eq("rdback_3", rs1_data, 32'hDEADBEEF); advance();
        wen = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234; rs2_addr = 5'd0;
        sample(); check_eq("x0_same", rs2_data, 32'd0); advance();
        idle();
        sample(); check_eq("x0_next", rs2_data, 32'd0); advance();

        // Same-cycle forwarding on both ports
        wen = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd7;
        sample();
        check_eq("byp_rs1", rs1_data, 32'hA5A5A5A5);
        check_eq("byp_rs2", rs2_data, 32'hA5A5A5A5);
        check_eq("nobyp_old", nb_rs1_data, 32'd0);
        advance();
        idle();
        sample(); check_eq("nobyp_new", nb_rs1_data, 32'hA5A5A5A5); advance();

        // Scoreboard lifecycle
        sb_set = 1'b1; sb_addr = 5'd10;
        sample(); advance();
        idle(); rs1_addr = 5'd10;
        sample();
        check_eq("sb_busy", {31'd0, rs1_busy}, 32'd1);
        check_eq("sb_any", {31'd0, any_busy}, 32'd1);
        advance();
        wen = 1'b1; rd_addr = 5'd10; rd_data = 32'h10;
        sample();
        check_eq("wb_byp_busy", {31'd0, rs1_busy}, 32'd0);
        check_eq("wb_nobyp_busy", {31'd0, nb_rs1_busy}, 32'd1);
        advance();
        idle();
        sample(); check_eq("wb_any_clr", {31'd0, any_busy}, 32'd0); advance();

        // Set/clear collision on register 12
        sb_set = 1'b1; sb_addr = 5'd12;
        sample(); advance();
        wen = 1'b1; rd_addr = 5'd12; rd_data = 32'h55;
        sample(); advance();
        idle(); rs1_addr = 5'd12;
        sample();
        check_eq("coll_data", rs1_data, 32'h55);
        check_eq("coll_busy", {31'd0, rs1_busy}, 32'd1);
        advance();

        // Reset mid-operation beats a simultaneous write
        wen = 1'b1; rd_addr = 5'd4; rd_data = 32'h77;
        sample(); advance();
        idle(); sb_set = 1'b1; sb_addr = 5'd4;
        sample(); advance();
        sb_addr = 5'd9;
        sample(); advance();
        idle(); rst = 1'b1; wen = 1'b1; rd_addr = 5'd4; rd_data = 32'h99; rs1_addr = 5'd4; rs2_addr = 5'd9;
        sample(); advance();
        idle();
        sample();
        check_eq("rst_mid_r4", rs1_data, 32'd0);
        check_eq("rst_mid_any", {31'd0, any_busy}, 32'd0);
        advance();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wen      = ($urandom_range(0, 1) == 1);
            sb_set   = ($urandom_range(0, 2) == 0);
            rd_addr  = 5'($urandom_range(0, 31));
            sb_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Second-generation integer register file for the npc core.
- Generalised in data width and register count; two combinational read ports and one enabled write port.
- Optional write-to-read bypass and a per-register scoreboard (pending-write bits) so decode can detect hazards against multi-cycle ops (loads, mul/div).
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hardwired zero
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy cleared; 0 = reads see only stored state

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wen  input  1  write enable for writeback port
rd_addr  input  ADDR_WIDTH  write index
rd_data  input  DATA_WIDTH  write data
rs1_addr  input  ADDR_WIDTH  read port 1 index
rs1_data  output  DATA_WIDTH  read port 1 data, combinational
rs1_busy  output  1  register rs1_addr has a pending write, combinational
rs2_addr  input  ADDR_WIDTH  read port 2 index
rs2_data  output  DATA_WIDTH  read port 2 data, combinational
rs2_busy  output  1  register rs2_addr has a pending write, combinational
sb_set  input  1  mark sb_addr pending (decode issued long-latency op)
sb_addr  input  ADDR_WIDTH  scoreboard set index
any_busy  output  1  OR of all busy bits (drain/fence indication)

Behaviour:
- Storage: registers 1..2**ADDR_WIDTH-1, DATA_WIDTH each; busy bit per register 1..N-1. Register 0 has no storage, reads 0, never busy.
- Reset (rst=1 at posedge): all registers to 0, all busy bits to 0. Takes priority over wen and sb_set in the same cycle. Immediately after reset: rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, any_busy=0 for any address.
- Write: at posedge with wen=1, rst=0, rd_addr!=0: reg[rd_addr] <= rd_data. wen with rd_addr=0 has no effect.
- Read: rsN_data = 0 if rsN_addr=0; else if BYPASS=1 and wen=1 and rd_addr=rsN_addr: rd_data; else reg[rsN_addr]. Zero-cycle latency; both ports independent, same address on both ports is legal.
- Scoreboard update at posedge (rst=0), per register i!=0:
  - sb_set=1 and sb_addr=i: busy[i] <= 1 (set wins over simultaneous clear of same index).
  - else wen=1 and rd_addr=i: busy[i] <= 0.
  - else hold.
- Writes to a non-busy register are legal and do not affect busy. sb_set on an already-busy register leaves it busy (single bit, no counting). sb_set with sb_addr=0 ignored.
- Busy outputs: rsN_busy = busy[rsN_addr], forced 0 for address 0. If BYPASS=1 and wen=1 and rd_addr=rsN_addr!=0, rsN_busy=0 in that cycle (data is forwarded). BYPASS=0: busy bit shown as stored.
- any_busy = OR of stored busy bits (no bypass term).
- No X on outputs after reset for any address combination.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, busy outputs 0, any_busy=0.
- Write/read back and x0: wen=1, rd_addr=3, rd_data=0xDEADBEEF; next cycle rs1_addr=3 -> 0xDEADBEEF. wen=1, rd_addr=0, rd_data=0x1234; rs2_addr=0 -> 0.
- Bypass: BYPASS=1, wen=1, rd_addr=7, rd_data=0xA5A5A5A5, rs1_addr=rs2_addr=7 same cycle -> both read 0xA5A5A5A5. BYPASS=0 build -> old value until next cycle.
- Scoreboard lifecycle: sb_set=1, sb_addr=10 -> next cycle rs1_addr=10 gives rs1_busy=1, any_busy=1. wen=1, rd_addr=10 -> rs1_busy=0 that cycle (BYPASS=1), stored bit cleared next cycle, any_busy=0.
- Set/clear collision: register 12 busy. Same cycle sb_set=1, sb_addr=12 and wen=1, rd_addr=12, rd_data=0x55 -> next cycle reg12=0x55, busy[12]=1.
- Reset mid-operation: busy bits 4 and 9 set, reg4=0x77. Assert rst together with wen=1, rd_addr=4, rd_data=0x99 -> next cycle reg4=0, all busy=0.
